// File: rtl/core_pkg.sv
// Shared front-end types and constants for the fetch stage.
// Pure declarations; no timing or backpressure of its own.
package core_pkg;

  typedef logic [31:0] xlen_t;

  localparam xlen_t RESET_VECTOR = 32'h0000_0000;
  localparam int    ILEN_BYTES   = 4;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } pc_state_t;

  // Granted fetch forwarded to IF/ID.
  typedef struct packed {
    xlen_t pc;
    xlen_t pc_plus4;
  } fetch_t;

  function automatic logic is_misaligned(input xlen_t addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/adder.sv
// 32-bit modulo-2^32 adder, purely combinational (zero latency).
// No handshake; result valid whenever the operands are.
module adder (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/pc_fetch.sv
// Fetch PC register and imem request stage; next PC one cycle after grant/redirect.
// Backpressure: stall_i suppresses new requests; an ungranted request holds addr/req until gnt.
module pc_fetch
  import core_pkg::*;
#(
  parameter xlen_t RESET_VECTOR = core_pkg::RESET_VECTOR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  output logic        fetch_valid_o,
  output logic [31:0] fetch_pc_o,
  output logic [31:0] fetch_pc_plus4_o,
  output logic        misaligned_o
);

  pc_state_t state_q, state_d;
  xlen_t     pc_q, pc_d;
  xlen_t     pend_pc_q, pend_pc_d;
  logic      pend_v_q, pend_v_d;
  logic      hold_q, hold_d;
  logic      mis_q, mis_d;

  xlen_t     pc_plus4;
  xlen_t     redir_tgt;
  logic      req;
  logic      gnt_fire;
  logic      stuck;
  logic      redir_take;
  fetch_t    fetch;

  adder u_pc_inc (
    .a   (pc_q),
    .b   (xlen_t'(ILEN_BYTES)),
    .sum (pc_plus4)
  );

  // A request raised but not granted pins the address, so redirects must wait.
  assign req        = (state_q == FETCH) && (!stall_i || hold_q);
  assign gnt_fire   = req && imem_gnt_i;
  assign stuck      = req && !imem_gnt_i;
  assign redir_take = (redirect_i || pend_v_q) && !stuck;
  assign redir_tgt  = redirect_i ? redirect_pc_i : pend_pc_q;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pend_v_d  = pend_v_q;
    pend_pc_d = pend_pc_q;
    mis_d     = mis_q;
    hold_d    = stuck;

    if (state_q == BOOT) begin
      state_d = FETCH;
    end

    if (redir_take) begin
      pc_d     = redir_tgt;
      pend_v_d = 1'b0;
      mis_d    = is_misaligned(redir_tgt);
      state_d  = is_misaligned(redir_tgt) ? HALT : FETCH;
    end else begin
      // Only reachable while stuck: park the target, latest one wins.
      if (redirect_i) begin
        pend_v_d  = 1'b1;
        pend_pc_d = redirect_pc_i;
      end
      if (gnt_fire) begin
        pc_d = pc_plus4;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= BOOT;
      pc_q      <= RESET_VECTOR;
      pend_pc_q <= RESET_VECTOR;
      pend_v_q  <= 1'b0;
      hold_q    <= 1'b0;
      mis_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pend_pc_q <= pend_pc_d;
      pend_v_q  <= pend_v_d;
      hold_q    <= hold_d;
      mis_q     <= mis_d;
    end
  end

  assign fetch.pc       = pc_q;
  assign fetch.pc_plus4 = pc_plus4;

  assign imem_req_o       = req;
  assign imem_addr_o      = pc_q;
  assign fetch_valid_o    = gnt_fire;
  assign fetch_pc_o       = fetch.pc;
  assign fetch_pc_plus4_o = fetch.pc_plus4;
  assign misaligned_o     = mis_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Bench for pc_fetch: directed scenarios then random traffic, scoreboarded against a cycle model.
module tb_pc_fetch;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        fetch_valid_o;
  logic [31:0] fetch_pc_o;
  logic [31:0] fetch_pc_plus4_o;
  logic        misaligned_o;

  always #5 clk = ~clk;

  pc_fetch dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .stall_i          (stall_i),
    .redirect_i       (redirect_i),
    .redirect_pc_i    (redirect_pc_i),
    .imem_req_o       (imem_req_o),
    .imem_addr_o      (imem_addr_o),
    .imem_gnt_i       (imem_gnt_i),
    .fetch_valid_o    (fetch_valid_o),
    .fetch_pc_o       (fetch_pc_o),
    .fetch_pc_plus4_o (fetch_pc_plus4_o),
    .misaligned_o     (misaligned_o)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  // Reference model: mode 0 = booting, 1 = running, 2 = halted.
  logic [31:0] m_pc, m_pend_pc;
  int          m_mode;
  bit          m_wait, m_pend_v, m_mis, m_fire, m_blk;
  logic        exp_req, exp_mis;
  logic [31:0] exp_addr;
  bit          mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc      = RESET_VECTOR;
    m_pend_pc = RESET_VECTOR;
    m_mode    = 0;
    m_wait    = 1'b0;
    m_pend_v  = 1'b0;
    m_mis     = 1'b0;
    exp_q.delete();
    exp_req   = 1'b0;
    exp_addr  = RESET_VECTOR;
    exp_mis   = 1'b0;
  endtask

  task automatic model_eval();
    logic [31:0] nxt;
    exp_req  = (m_mode == 1) && (!stall_i || m_wait);
    m_fire   = exp_req && imem_gnt_i;
    m_blk    = exp_req && !imem_gnt_i;
    exp_addr = m_pc;
    exp_mis  = m_mis;
    if (m_fire) begin
      nxt = m_pc + 32'd4;
      exp_q.push_back('{pc: m_pc, pc4: nxt});
    end
  endtask

  task automatic model_update();
    logic [31:0] tgt;
    if ((redirect_i || m_pend_v) && !m_blk) begin
      tgt      = redirect_i ? redirect_pc_i : m_pend_pc;
      m_pc     = tgt;
      m_pend_v = 1'b0;
      m_mis    = (tgt % 4) != 0;
      m_mode   = m_mis ? 2 : 1;
    end else begin
      if (redirect_i) begin
        m_pend_v  = 1'b1;
        m_pend_pc = redirect_pc_i;
      end
      if (m_fire) m_pc = m_pc + 32'd4;
      if (m_mode == 0) m_mode = 1;
    end
    m_wait = m_blk;
  endtask

  // One clock cycle of stimulus; entered and left on a falling edge.
  task automatic cycle(input bit s, input bit g, input bit r, input logic [31:0] t);
    stall_i       = s;
    imem_gnt_i    = g;
    redirect_i    = r;
    redirect_pc_i = t;
    model_eval();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      #2;
      check("imem_req", {31'b0, imem_req_o}, {31'b0, exp_req});
      check("imem_addr", imem_addr_o, exp_addr);
      check("misaligned", {31'b0, misaligned_o}, {31'b0, exp_mis});
      if (fetch_valid_o) begin
        if (exp_q.size() == 0) begin
          check("unexpected_fetch", fetch_pc_o, 32'hxxxx_xxxx);
        end else begin
          mon_e = exp_q.pop_front();
          check("fetch_pc", fetch_pc_o, mon_e.pc);
          check("fetch_pc_plus4", fetch_pc_plus4_o, mon_e.pc4);
        end
      end
      checks++;
      if (exp_q.size() != 0) begin
        errors++;
        $display("FAIL missed_fetch: got no fetch_valid expected pc %h at %0t", exp_q[0].pc, $time);
        exp_q.delete();
      end
    end
  end

  initial begin
    logic [31:0] tgt;
    rst_n = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0; imem_gnt_i = 1'b1;
    model_reset();
    #12;
    check("rst_req", {31'b0, imem_req_o}, 32'd0);
    check("rst_valid", {31'b0, fetch_valid_o}, 32'd0);
    check("rst_addr", imem_addr_o, RESET_VECTOR);
    check("rst_fetch_pc", fetch_pc_o, RESET_VECTOR);
    check("rst_plus4", fetch_pc_plus4_o, RESET_VECTOR + 32'd4);
    check("rst_mis", {31'b0, misaligned_o}, 32'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Boot cycle, then 0x0 and 0x4 back to back.
    cycle(0, 1, 0, 0);
    cycle(0, 1, 0, 0);
    cycle(0, 1, 0, 0);
    check("seq_addr_8", imem_addr_o, 32'h8);
    // Backpressure at 0x8: three ungranted cycles, stall rises in the second.
    cycle(0, 0, 0, 0);
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    check("bp_hold_addr", imem_addr_o, 32'h8);
    cycle(1, 1, 0, 0);
    cycle(1, 1, 0, 0);
    cycle(0, 1, 0, 0);
    // Two redirects while 0x10 is ungranted; the later one wins after grant.
    cycle(0, 0, 1, 32'h100);
    cycle(0, 0, 1, 32'h200);
    cycle(0, 1, 0, 0);
    check("pend_latest_addr", imem_addr_o, 32'h200);
    cycle(0, 1, 0, 0);
    cycle(0, 1, 1, 32'h300);
    check("redir_with_gnt_addr", imem_addr_o, 32'h300);
    // Misaligned target halts; an aligned redirect recovers.
    cycle(0, 1, 1, 32'hFA00_0006);
    check("mis_set", {31'b0, misaligned_o}, 32'd1);
    check("mis_addr", imem_addr_o, 32'hFA00_0006);
    cycle(0, 1, 0, 0);
    cycle(0, 1, 1, 32'hFF00_0008);
    check("mis_clear", {31'b0, misaligned_o}, 32'd0);
    cycle(0, 1, 0, 0);
    // Wrap-around of PC+4.
    cycle(0, 1, 1, 32'hFFFF_FFFC);
    stall_i = 1'b0; imem_gnt_i = 1'b1; redirect_i = 1'b0;
    #1;
    check("wrap_plus4", fetch_pc_plus4_o, 32'h0);
    cycle(0, 1, 0, 0);
    check("wrap_addr", imem_addr_o, 32'h0);
    // Async reset with a parked redirect.
    cycle(0, 1, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 1, 32'h40);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("arst_req", {31'b0, imem_req_o}, 32'd0);
    check("arst_addr", imem_addr_o, RESET_VECTOR);
    check("arst_plus4", fetch_pc_plus4_o, RESET_VECTOR + 32'd4);
    imem_gnt_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(0, 1, 0, 0);
    check("arst_first_addr", imem_addr_o, RESET_VECTOR);
    cycle(0, 1, 0, 0);

    for (int i = 0; i < 1500; i++) begin
      tgt = $urandom;
      if ($urandom_range(0, 7) != 0) tgt[1:0] = 2'b00;
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 4) < 3,
            $urandom_range(0, 9) == 0, tgt);
    end

    @(negedge clk);
    #3;
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
